// File: rtl/nbit_cmp_serial.sv
// Multi-cycle signed/unsigned magnitude comparator.
// Scans the captured operands one D-bit digit per cycle, MSB first. It stops on the
// first digit that differs, or after the last digit when the operands are equal.
// Signed compares invert both MSBs at capture (offset-binary), so the scan is always unsigned.
module nbit_cmp_serial #(
  parameter int unsigned N = 32,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic         result,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int unsigned NDig = N / D;
  localparam int unsigned KW   = (NDig > 1) ? $clog2(NDig) : 1;
  localparam logic [KW-1:0] KTop = KW'(NDig - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          done_q, done_d;
  logic          result_q, result_d;
  logic          lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [N-1:0]  a_shift, b_shift;
  logic [D-1:0]  a_dig, b_dig;

  // Map the decided relation onto the captured result op.
  function automatic logic sel_result(input logic [1:0] o, input logic l, input logic e);
    logic r;
    unique case (o)
      2'b00:   r = l;
      2'b01:   r = l | e;
      2'b10:   r = e;
      default: r = ~e;
    endcase
    return r;
  endfunction

  // Extract digit k of both captured operands.
  always_comb begin
    a_shift = a_q >> (int'(k_q) * int'(D));
    b_shift = b_q >> (int'(k_q) * int'(D));
    a_dig   = a_shift[D-1:0];
    b_dig   = b_shift[D-1:0];
  end

  // Next-state logic: capture on start, scan one digit per cycle, decide and return to idle.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    done_d   = 1'b0;
    result_d = result_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d        = a;
          b_d        = b;
          // Flipping both MSBs turns a two's-complement order into an unsigned one.
          a_d[N-1]   = a[N-1] ^ signed_mode;
          b_d[N-1]   = b[N-1] ^ signed_mode;
          op_d       = op;
          k_d        = KTop;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (a_dig != b_dig) begin
          lt_d     = (a_dig < b_dig);
          gt_d     = (a_dig > b_dig);
          eq_d     = 1'b0;
          result_d = sel_result(op_q, a_dig < b_dig, 1'b0);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (k_q == '0) begin
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b1;
          result_d = sel_result(op_q, 1'b0, 1'b1);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      done_q   <= done_d;
      result_q <= result_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
    end
  end

  assign busy   = (state_q == StScan);
  assign done   = done_q;
  assign result = result_q;
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign gt     = gt_q;

endmodule

// File: tb/tb_nbit_cmp_serial.sv
// Self-checking bench for nbit_cmp_serial (N=8, D=2).
// A cycle-level reference model is compared against the DUT every cycle.
// Directed cases with hand-computed expectations pin the model.
module tb_nbit_cmp_serial;
  localparam int N = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         signed_mode = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         busy, done, result, lt, eq, gt;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  nbit_cmp_serial #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .op(op), .busy(busy), .done(done), .result(result), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer compare; latency from the highest differing bit.
  function automatic void model_eval(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic sm, input logic [1:0] o,
                                     output logic l, output logic e, output logic g,
                                     output logic r, output int j);
    int vx, vy;
    vx = sm ? int'($signed(x)) : int'(x);
    vy = sm ? int'($signed(y)) : int'(y);
    l = (vx < vy);
    e = (vx == vy);
    g = (vx > vy);
    case (o)
      2'b00:   r = l;
      2'b01:   r = l | e;
      2'b10:   r = e;
      default: r = !e;
    endcase
    j = N / D;
    for (int i = 0; i < N; i++) if (x[i] != y[i]) j = N / D - i / D;
  endfunction

  logic c_lt, c_eq, c_gt, c_res;
  int   c_j;
  always_comb model_eval(a, b, signed_mode, op, c_lt, c_eq, c_gt, c_res, c_j);

  logic m_busy = 1'b0, m_done = 1'b0, m_res = 1'b0, m_lt = 1'b0, m_eq = 1'b0, m_gt = 1'b0;
  logic p_res, p_lt, p_eq, p_gt;
  int   m_left = 0;

  // Timeline model: accept when idle, decide j edges later, pulse done one cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= 1'b0;
      m_lt   <= 1'b0; m_eq   <= 1'b0; m_gt  <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_res <= p_res; m_lt <= p_lt; m_eq <= p_eq; m_gt <= p_gt;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= c_j;
        p_res <= c_res; p_lt <= c_lt; p_eq <= c_eq; p_gt <= c_gt;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en)
      check("cycle_outputs", {26'd0, busy, done, result, lt, eq, gt},
            {26'd0, m_busy, m_done, m_res, m_lt, m_eq, m_gt});
  end

  // One compare with literal expectations; exp_f = {lt, eq, gt, result}.
  task automatic run_cmp(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic sm, input logic [1:0] o, input int exp_j,
                         input logic [3:0] exp_f);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = sm; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); signed_mode = 1'($urandom); op = 2'($urandom);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, exp_j);
    check({name, "_flags"}, {28'd0, lt, eq, gt, result}, {28'd0, exp_f});
  endtask

  initial begin
    int n_done, first_d, second_d;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_state", {26'd0, busy, done, result, lt, eq, gt}, 32'd0);
    rst = 1'b0;

    run_cmp("u_80_7f", 8'h80, 8'h7F, 1'b0, 2'b00, 1, 4'b0010);
    run_cmp("s_80_7f", 8'h80, 8'h7F, 1'b1, 2'b00, 1, 4'b1001);
    run_cmp("s_ff_01", 8'hFF, 8'h01, 1'b1, 2'b00, 1, 4'b1001);
    run_cmp("u_ff_01", 8'hFF, 8'h01, 1'b0, 2'b00, 1, 4'b0010);
    run_cmp("eq_sle",  8'h5A, 8'h5A, 1'b0, 2'b01, 4, 4'b0101);
    run_cmp("eq_seq",  8'h5A, 8'h5A, 1'b0, 2'b10, 4, 4'b0101);
    run_cmp("eq_sne",  8'h5A, 8'h5A, 1'b0, 2'b11, 4, 4'b0100);
    run_cmp("u_12_13", 8'h12, 8'h13, 1'b0, 2'b00, 4, 4'b1001);

    // Start pulsed while busy must be ignored: exactly one done.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; op = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("ignored_start_done_count", n_done, 1);
    check("ignored_start_flags", {28'd0, lt, eq, gt, result}, 32'b1001);

    // Start held high: next compare accepted the cycle after done.
    a = 8'h80; b = 8'h7F; signed_mode = 1'b0; op = 2'b00; start = 1'b1;
    first_d = 0; second_d = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done && first_d == 0) first_d = i;
      else if (done && second_d == 0) second_d = i;
    end
    start = 1'b0;
    check("b2b_first_done", first_d, 2);
    check("b2b_gap", second_d - first_d, 2);
    repeat (3) @(negedge clk);

    // Reset in the second SCAN cycle aborts without a done pulse.
    a = 8'h5A; b = 8'h5A; op = 2'b10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("mid_scan_reset", {26'd0, busy, done, result, lt, eq, gt}, 32'd0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_abort", n_done, 0);
    run_cmp("after_reset", 8'h3C, 8'h3D, 1'b0, 2'b01, 4, 4'b1001);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a = N'($urandom);
      case ($urandom_range(3))
        0:       b = a;
        1:       b = a ^ N'(1 << $urandom_range(N - 1));
        default: b = N'($urandom);
      endcase
      signed_mode = 1'($urandom);
      op = 2'($urandom);
      start = ($urandom_range(2) != 0);
      rst = ($urandom_range(99) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nbit_cmp_serial.md
# nbit_cmp_serial

Parametrised, multi-cycle magnitude comparator for the ALU datapath. It extends the single-cycle signed less-than function to selectable signed or unsigned compares and four result ops (slt, sle, seq, sne). It scans operands D bits per cycle from the MSB and terminates early on the first differing digit. Operands and mode are captured under a start/busy/done handshake, so the ALU can share the unit across instructions.

## Interface
Parameters:
- N, 32, operand width in bits; N ≥ 2.
- D, 4, digit width (bits compared per cycle); 1 ≤ D ≤ N, N % D == 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; honoured only when busy=0.
- a  input  N  left operand; sampled on the accepted start edge.
- b  input  N  right operand; sampled on the accepted start edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- op  input  2  result select, sampled with a/b: 00 slt (a<b), 01 sle (a≤b), 10 seq (a==b), 11 sne (a!=b).
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when result/flags update.
- result  output  1  selected op outcome; held until the next done.
- lt  output  1  a<b under the captured mode; held.
- eq  output  1  a==b; held.
- gt  output  1  a>b under the captured mode; held.

## Operation
- States: IDLE, SCAN.
- IDLE, start=1: capture a, b, signed_mode, op into internal registers. Set digit index k = N/D−1. Go to SCAN.
- Signed handling: in signed mode, the captured MSB of both operands is inverted (offset-binary). The whole compare then proceeds as unsigned. Inversion is applied at capture, not per cycle.
- SCAN, each cycle: compare digit k of the captured operands, bits [k·D+D−1 : k·D].
  - Digits differ: set lt/gt from the digit compare, eq=0, compute result, go to IDLE.
  - Digits equal and k==0: set eq=1, lt=0, gt=0, compute result, go to IDLE.
  - Otherwise: k ← k−1 and stay in SCAN.
- result: slt=lt; sle=lt|eq; seq=eq; sne=~eq.
- Exactly one of lt/eq/gt is 1 after any completed compare.
- start while busy=1 is ignored. No queueing and no error flag.
- The a/b/op/signed_mode inputs may change freely after capture without affecting the compare in flight.

## Timing
- Reset values: busy=0, done=0, result=0, lt=0, eq=0, gt=0. State IDLE, k=0, captured operands 0.
- Start accepted at edge E0. busy=1 from E0 until the deciding edge Ed.
- Ed = E0 + j, where j = number of digits examined. j runs from 1 (MSB digit differs) to N/D (differ only in the last digit, or equal).
- At Ed: flags and result update, busy falls, and done=1 for exactly one cycle, deasserting at Ed+1.
- The start→done latency is therefore j cycles.
- Back-to-back: start may be high in the cycle done is high. That start is accepted at Ed+1, because the state is already IDLE. Sustained throughput is one compare per j+1 cycles.
- rst=1 at any edge, including mid-SCAN: returns to reset values at that edge. The aborted compare never pulses done. rst takes priority over start.
- Flags and result are registered outputs; there is no combinational path from inputs to outputs.

## Test plan
Bench parameters: N=8, D=2, so 4 digits.
- Unsigned, a=0x80, b=0x7F, op=00: start → done after 1 cycle with gt=1, lt=0, eq=0, result=0.
- Same operands, signed_mode=1: done after 1 cycle with lt=1, result=1 (−128<127).
- a=0xFF, b=0x01: signed gives lt=1 (−1<1); unsigned gives gt=1. Both finish in 1 cycle.
- a=b=0x5A with op=01, then op=10, then op=11: each done after 4 cycles with eq=1, lt=gt=0. Results are 1, 1, 0 respectively.
- a=0x12, b=0x13, unsigned, op=00: busy for 4 cycles, done with lt=1, result=1. A second start asserted during busy is ignored, and exactly one done pulse is seen.
- Back-to-back and reset:
  - Start held high through done: the second compare begins at the cycle after done.
  - rst asserted in the 2nd SCAN cycle of a 4-digit compare: busy=0 and all flags 0 at the next edge, with no done pulse.
  - A fresh start afterwards completes normally.
